// File: rtl/ul_rd_ram_control_s.sv
// ---------------------------------------------------------------------------
// ul_rd_ram_control_s
//
// Read side of the uplink ping-pong RAM. It watches the writer's per-bank
// full flags, reads one full bank as a frame of FRAME_LEN 10-bit words, and
// streams the words to the uplink sender over a valid/ready handshake. When
// the whole frame has been accepted, it returns a one-cycle release pulse for
// that bank so the writer can clear its full flag.
//
// Ports
//   clk             system clock
//   nRst            synchronous active-low reset
//   UlRAM_wr_state  bank full flags from the writer (bit0=RAM0, bit1=RAM1)
//   rdUlRAMAddr     RAM read address (0 when no read is issued)
//   rdUlRAMEn       RAM read enable; rdUlRAMData is valid one cycle later
//   rdUlRAMData     RAM read data
//   UlRAM_rd_state  one-cycle bank release pulse (bit0=RAM0, bit1=RAM1)
//   outData         frame word to the sender
//   outValid        outData valid
//   outReady        sender accepts the word when outValid && outReady
//   outSof          marks the first word of a frame
//   outEof          marks the last word of a frame
//   rdBusy          high from bank selection until the release cycle
//   frameCnt        frames released since reset (wraps)
// ---------------------------------------------------------------------------
module ul_rd_ram_control_s #(
    parameter int          FRAME_LEN = 262,
    parameter logic [9:0]  RAM0_BASE = 10'd0,
    parameter logic [9:0]  RAM1_BASE = 10'd512
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [1:0]  UlRAM_wr_state,
    output logic [9:0]  rdUlRAMAddr,
    output logic        rdUlRAMEn,
    input  logic [9:0]  rdUlRAMData,
    output logic [1:0]  UlRAM_rd_state,
    output logic [9:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        outSof,
    output logic        outEof,
    output logic        rdBusy,
    output logic [15:0] frameCnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_GUARD   = 3'd4;

    localparam logic [8:0] LEN9  = 9'(FRAME_LEN);
    localparam logic [8:0] LAST9 = 9'(FRAME_LEN - 1);

    logic [2:0]  state_q,      state_d;
    logic        bank_q,       bank_d;
    logic        bank_ptr_q,   bank_ptr_d;
    logic [8:0]  issue_cnt_q,  issue_cnt_d;
    logic [8:0]  accept_cnt_q, accept_cnt_d;
    logic        inflight_q,   inflight_d;
    logic        infl_sof_q,   infl_sof_d;
    logic        infl_eof_q,   infl_eof_d;
    // Buffer entries hold {sof, eof, data}; buf0 is the head.
    logic [11:0] buf0_q,       buf0_d;
    logic [11:0] buf1_q,       buf1_d;
    logic [1:0]  buf_cnt_q,    buf_cnt_d;
    logic [15:0] frame_cnt_q,  frame_cnt_d;

    logic        pop;
    logic        issue;
    logic [1:0]  occ;
    logic [1:0]  cnt_mid;
    logic [9:0]  base;

    always_comb begin
        base = bank_q ? RAM1_BASE : RAM0_BASE;
        pop  = (buf_cnt_q != 2'd0) && outReady;

        // Occupancy counts the word leaving this cycle as already gone, so a
        // read can be issued every cycle while the sender keeps up.
        occ   = buf_cnt_q - 2'(pop) + 2'(inflight_q);
        issue = (state_q == S_READ) && (issue_cnt_q < LEN9) && (occ < 2'd2);

        // Two-entry FIFO: pop shifts the tail into the head, the RAM return
        // lands in the first free slot after the pop.
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        cnt_mid = buf_cnt_q - 2'(pop);
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (cnt_mid == 2'd0) begin
                buf0_d = {infl_sof_q, infl_eof_q, rdUlRAMData};
            end else begin
                buf1_d = {infl_sof_q, infl_eof_q, rdUlRAMData};
            end
        end
        buf_cnt_d = cnt_mid + 2'(inflight_q);

        // Frame markers travel with the read so they line up with its data.
        inflight_d = issue;
        infl_sof_d = (issue_cnt_q == 9'd0);
        infl_eof_d = (issue_cnt_q == LAST9);

        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        if (issue && (issue_cnt_q < LEN9)) begin
            issue_cnt_d = issue_cnt_q + 9'd1;
        end
        if (pop && (accept_cnt_q < LEN9)) begin
            accept_cnt_d = accept_cnt_q + 9'd1;
        end

        state_d     = state_q;
        bank_d      = bank_q;
        bank_ptr_d  = bank_ptr_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                // The pointer bank wins ties, which keeps frames alternating.
                if (UlRAM_wr_state[bank_ptr_q]) begin
                    bank_d       = bank_ptr_q;
                    issue_cnt_d  = 9'd0;
                    accept_cnt_d = 9'd0;
                    state_d      = S_READ;
                end else if (UlRAM_wr_state[~bank_ptr_q]) begin
                    bank_d       = ~bank_ptr_q;
                    issue_cnt_d  = 9'd0;
                    accept_cnt_d = 9'd0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (issue && (issue_cnt_q == LAST9)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept_cnt_q == LEN9) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                bank_ptr_d  = ~bank_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = S_GUARD;
            end
            S_GUARD: begin
                // One idle cycle lets the writer's flag clear propagate.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q      <= S_IDLE;
            bank_q       <= 1'b0;
            bank_ptr_q   <= 1'b0;
            issue_cnt_q  <= 9'd0;
            accept_cnt_q <= 9'd0;
            inflight_q   <= 1'b0;
            infl_sof_q   <= 1'b0;
            infl_eof_q   <= 1'b0;
            buf0_q       <= 12'd0;
            buf1_q       <= 12'd0;
            buf_cnt_q    <= 2'd0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            bank_ptr_q   <= bank_ptr_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            inflight_q   <= inflight_d;
            infl_sof_q   <= infl_sof_d;
            infl_eof_q   <= infl_eof_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            buf_cnt_q    <= buf_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        rdUlRAMEn      = issue;
        rdUlRAMAddr    = issue ? (base + {1'b0, issue_cnt_q}) : 10'd0;
        UlRAM_rd_state = (state_q == S_RELEASE) ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
        outValid       = (buf_cnt_q != 2'd0);
        outData        = outValid ? buf0_q[9:0] : 10'd0;
        outSof         = outValid & buf0_q[11];
        outEof         = outValid & buf0_q[10];
        rdBusy         = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_RELEASE);
        frameCnt       = frame_cnt_q;
    end

endmodule
